pll_lock_sequencer: RTL and testbench

//  Controller for the system PLL (50 MHz refclk -> 100/200 MHz). Runs on refclk, drives the PLL

---
 rtl/pll_lock_sequencer_pkg.sv | 52 +++++
 rtl/sync_2ff.sv | 22 ++
 rtl/pll_lock_sequencer.sv | 132 +++++++++++++
 tb/tb_pll_lock_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_sequencer_pkg.sv
// rtl/pll_lock_sequencer_pkg.sv - state encodings, default timing constants and sizing helpers
package pll_lock_sequencer_pkg;

    // Sequencer states; encodings are fixed so firmware/debug readouts stay stable
    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } pll_state_e;

    // Default timing for a 50 MHz refclk
    localparam int DEF_RST_PULSE_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_MAX_RETRIES         = 3;

    // Output bundle registered alongside the state
    typedef struct packed {
        logic pll_rst;
        logic sys_rst;
        logic pll_ready;
        logic fault;
    } pll_outs_t;

    // Output levels that belong to each state
    function automatic pll_outs_t state_outputs(input pll_state_e s);
        pll_outs_t o;
        o.pll_rst   = (s == ST_RESET_PLL) || (s == ST_FAULT);
        o.sys_rst   = (s != ST_RUN);
        o.pll_ready = (s == ST_RUN);
        o.fault     = (s == ST_FAULT);
        return o;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // $clog2 that never yields a zero-width vector
    function automatic int clog2_min1(input int v);
        int w;
        w = $clog2(v);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop single-bit synchronizer, both flops reset to 0
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Capture the asynchronous input and let any metastability settle for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset/lock qualification sequencer with retry and fault latch
module pll_lock_sequencer
    import pll_lock_sequencer_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
    localparam int RW = clog2_min1(MAX_RETRIES + 1)
) (
    input  logic          refclk,
    input  logic          rst,
    input  logic          pll_locked,
    input  logic          relock_req,
    output logic          pll_rst,
    output logic          sys_rst,
    output logic          pll_ready,
    output logic          fault,
    output logic [RW-1:0] retry_count
);

    // One counter serves all three timed states, so size it for the longest
    localparam int CW = clog2_min1(max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES));

    // Terminal values: each fires one cycle before the duration elapses, so the
    // counter never needs to represent the duration itself and cannot wrap
    localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

    pll_state_e    state;
    logic [CW-1:0] count;
    pll_outs_t     outs;
    logic          locked_s;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    assign pll_rst   = outs.pll_rst;
    assign sys_rst   = outs.sys_rst;
    assign pll_ready = outs.pll_ready;
    assign fault     = outs.fault;

    // Sequencer: state, shared cycle counter, retry register and outputs decoded from the next state
    always_ff @(posedge refclk) begin
        if (rst) begin
            state       <= ST_RESET_PLL;
            count       <= '0;
            retry_count <= '0;
            outs        <= state_outputs(ST_RESET_PLL);
        end else begin
            case (state)
                ST_RESET_PLL: begin
                    if (count == RST_LAST) begin
                        state <= ST_WAIT_LOCK;
                        outs  <= state_outputs(ST_WAIT_LOCK);
                        count <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end

                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state <= ST_STABLE;
                        outs  <= state_outputs(ST_STABLE);
                        count <= '0;
                    end else if (count == TIMEOUT_LAST) begin
                        count <= '0;
                        if (retry_count == RETRY_MAX) begin
                            state <= ST_FAULT;
                            outs  <= state_outputs(ST_FAULT);
                        end else begin
                            retry_count <= retry_count + 1'b1;
                            state       <= ST_RESET_PLL;
                            outs        <= state_outputs(ST_RESET_PLL);
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end

                ST_STABLE: begin
                    // A lock dropout here only restarts qualification; the PLL is
                    // not reset and the attempt is not charged as a retry
                    if (!locked_s) begin
                        state <= ST_WAIT_LOCK;
                        outs  <= state_outputs(ST_WAIT_LOCK);
                        count <= '0;
                    end else if (count == STABLE_LAST) begin
                        state <= ST_RUN;
                        outs  <= state_outputs(ST_RUN);
                        count <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end

                ST_RUN: begin
                    if (!locked_s || relock_req) begin
                        state       <= ST_RESET_PLL;
                        outs        <= state_outputs(ST_RESET_PLL);
                        count       <= '0;
                        retry_count <= '0;
                    end
                end

                ST_FAULT: begin
                    if (relock_req) begin
                        state       <= ST_RESET_PLL;
                        outs        <= state_outputs(ST_RESET_PLL);
                        count       <= '0;
                        retry_count <= '0;
                    end
                end

                default: begin
                    state       <= ST_RESET_PLL;
                    outs        <= state_outputs(ST_RESET_PLL);
                    count       <= '0;
                    retry_count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - self-checking bench for pll_lock_sequencer
module tb_pll_lock_sequencer;

    localparam int P_RST = 4;
    localparam int P_TO  = 20;
    localparam int P_ST  = 8;
    localparam int P_MR  = 2;

    localparam int PH_RESET  = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_STABLE = 2;
    localparam int PH_RUN    = 3;
    localparam int PH_FAULT  = 4;

    logic       refclk     = 1'b0;
    logic       rst        = 1'b1;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       pll_ready;
    logic       fault;
    logic [1:0] retry_count;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 refclk = ~refclk;

    pll_lock_sequencer #(
        .RST_PULSE_CYCLES    (P_RST),
        .LOCK_TIMEOUT_CYCLES (P_TO),
        .LOCK_STABLE_CYCLES  (P_ST),
        .MAX_RETRIES         (P_MR)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .relock_req  (relock_req),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .pll_ready   (pll_ready),
        .fault       (fault),
        .retry_count (retry_count)
    );

    // Reference model: each phase has an absolute deadline edge; the synchronized
    // lock flag is simply pll_locked as seen two edges earlier
    int         m_edge     = 0;
    int         m_phase    = PH_RESET;
    int         m_deadline = 0;
    int         m_retry    = 0;
    logic [1:0] m_hist     = 2'b00;

    always @(posedge refclk) begin
        m_edge <= m_edge + 1;
        if (rst) begin
            m_phase    <= PH_RESET;
            m_deadline <= m_edge + P_RST;
            m_retry    <= 0;
            m_hist     <= 2'b00;
        end else begin
            m_hist <= {m_hist[0], pll_locked};
            case (m_phase)
                PH_RESET: if (m_edge == m_deadline) begin
                    m_phase    <= PH_WAIT;
                    m_deadline <= m_edge + P_TO;
                end
                PH_WAIT: if (m_hist[1]) begin
                    m_phase    <= PH_STABLE;
                    m_deadline <= m_edge + P_ST;
                end else if (m_edge == m_deadline) begin
                    if (m_retry >= P_MR) begin
                        m_phase <= PH_FAULT;
                    end else begin
                        m_retry    <= m_retry + 1;
                        m_phase    <= PH_RESET;
                        m_deadline <= m_edge + P_RST;
                    end
                end
                PH_STABLE: if (!m_hist[1]) begin
                    m_phase    <= PH_WAIT;
                    m_deadline <= m_edge + P_TO;
                end else if (m_edge == m_deadline) begin
                    m_phase <= PH_RUN;
                end
                PH_RUN: if (!m_hist[1] || relock_req) begin
                    m_phase    <= PH_RESET;
                    m_deadline <= m_edge + P_RST;
                    m_retry    <= 0;
                end
                PH_FAULT: if (relock_req) begin
                    m_phase    <= PH_RESET;
                    m_deadline <= m_edge + P_RST;
                    m_retry    <= 0;
                end
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
        chk({tag, "_sys_rst"}, 32'(sys_rst), 32'd1);
        chk({tag, "_pll_ready"}, 32'(pll_ready), 32'd0);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
        chk({tag, "_retry"}, 32'(retry_count), 32'd0);
    endtask

    // Every-cycle comparison of the DUT against the model
    initial begin
        forever begin
            @(negedge refclk);
            if (chk_en) begin
                chk("m_pll_rst", 32'(pll_rst), 32'((m_phase == PH_RESET) || (m_phase == PH_FAULT)));
                chk("m_sys_rst", 32'(sys_rst), 32'(m_phase != PH_RUN));
                chk("m_pll_ready", 32'(pll_ready), 32'(m_phase == PH_RUN));
                chk("m_fault", 32'(fault), 32'(m_phase == PH_FAULT));
                chk("m_retry", 32'(retry_count), 32'(m_retry));
            end
        end
    end

    initial begin
        // Bring-up
        rst = 1'b1;
        repeat (3) step();
        chk_en = 1'b1;
        rst = 1'b0;
        chk_reset("t1_reset");
        repeat (3) step();
        chk("t1_pll_rst_held", 32'(pll_rst), 32'd1);
        step();
        chk("t1_pll_rst_released", 32'(pll_rst), 32'd0);
        chk("t1_sys_rst_wait", 32'(sys_rst), 32'd1);
        repeat (5) step();
        pll_locked = 1'b1;
        repeat (10) step();
        chk("t1_ready_early", 32'(pll_ready), 32'd0);
        step();
        chk("t1_ready_t11", 32'(pll_ready), 32'd1);
        chk("t1_sys_rst_t11", 32'(sys_rst), 32'd0);

        // Loss of lock in RUN
        repeat (3) step();
        pll_locked = 1'b0;
        repeat (2) step();
        chk("t4_still_run", 32'(pll_ready), 32'd1);
        step();
        chk("t4_pll_rst_t3", 32'(pll_rst), 32'd1);
        chk("t4_sys_rst_t3", 32'(sys_rst), 32'd1);
        chk("t4_retry_t3", 32'(retry_count), 32'd0);
        repeat (3) step();
        chk("t4_pulse_end_held", 32'(pll_rst), 32'd1);
        step();
        chk("t4_pulse_done", 32'(pll_rst), 32'd0);

        // relock_req has no effect while waiting for lock
        relock_req = 1'b1;
        step();
        relock_req = 1'b0;
        chk("ign_relock_wait", 32'(pll_rst), 32'd0);

        // Glitch while qualifying lock
        repeat (2) step();
        pll_locked = 1'b1;
        repeat (5) step();
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        repeat (10) step();
        chk("t3_ready_early", 32'(pll_ready), 32'd0);
        chk("t3_no_pll_rst", 32'(pll_rst), 32'd0);
        step();
        chk("t3_ready_t11", 32'(pll_ready), 32'd1);
        chk("t3_retry_same", 32'(retry_count), 32'd0);

        // Software relock from RUN, then rst while in WAIT_LOCK
        relock_req = 1'b1;
        step();
        relock_req = 1'b0;
        chk("relock_run_pll_rst", 32'(pll_rst), 32'd1);
        chk("relock_run_ready", 32'(pll_ready), 32'd0);
        repeat (4) step();
        chk("t6a_in_wait", 32'(pll_rst), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset("t6a_reset");
        repeat (12) step();
        chk("t6a_ready_early", 32'(pll_ready), 32'd0);
        step();
        chk("t6a_ready_e13", 32'(pll_ready), 32'd1);

        // rst while in RUN
        rst = 1'b1;
        step();
        chk_reset("t6b_reset");
        pll_locked = 1'b0;
        rst = 1'b0;

        // Never lock: three attempts then FAULT
        for (int k = 1; k <= 72; k++) begin
            step();
            if (k == 4) begin
                chk("t2_wait1_pll_rst", 32'(pll_rst), 32'd0);
                chk("t2_wait1_retry", 32'(retry_count), 32'd0);
            end
            if (k == 24) begin
                chk("t2_retry1_pll_rst", 32'(pll_rst), 32'd1);
                chk("t2_retry1", 32'(retry_count), 32'd1);
            end
            if (k == 28) chk("t2_wait2_pll_rst", 32'(pll_rst), 32'd0);
            if (k == 48) chk("t2_retry2", 32'(retry_count), 32'd2);
            if (k == 71) chk("t2_fault_early", 32'(fault), 32'd0);
            if (k == 72) begin
                chk("t2_fault_c72", 32'(fault), 32'd1);
                chk("t2_fault_pll_rst", 32'(pll_rst), 32'd1);
                chk("t2_fault_sys_rst", 32'(sys_rst), 32'd1);
            end
        end
        repeat (5) step();
        chk("t2_fault_sticky", 32'(fault), 32'd1);

        // relock_req leaves FAULT
        relock_req = 1'b1;
        step();
        relock_req = 1'b0;
        chk("t5_fault_clear", 32'(fault), 32'd0);
        chk("t5_retry_clear", 32'(retry_count), 32'd0);
        chk("t5_pll_rst", 32'(pll_rst), 32'd1);
        repeat (3) step();
        chk("t5_pulse_held", 32'(pll_rst), 32'd1);
        step();
        chk("t5_pulse_done", 32'(pll_rst), 32'd0);
        pll_locked = 1'b1;
        repeat (11) step();
        chk("t5_run", 32'(pll_ready), 32'd1);

        // relock_req coincident with observed lock loss: one transition, one pulse
        repeat (2) step();
        pll_locked = 1'b0;
        repeat (2) step();
        relock_req = 1'b1;
        step();
        relock_req = 1'b0;
        chk("both_pll_rst", 32'(pll_rst), 32'd1);
        repeat (3) step();
        chk("both_pulse_held", 32'(pll_rst), 32'd1);
        step();
        chk("both_pulse_done", 32'(pll_rst), 32'd0);
        chk("both_retry", 32'(retry_count), 32'd0);

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
